// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
// Shared definitions for the two-requester UART transmit arbiter.
//   - arb_state_t      : arbiter FSM state encoding
//   - ASCII_CR/ASCII_LF : line terminator bytes appended when the
//                         UART_ARB_CRLF_EN macro is defined
//   - MAXBYTES_DEFAULT  : default maximum message length in bytes
// Configuration macro: UART_ARB_CRLF_EN (adds the CR and LF states).
// ---------------------------------------------------------------------------
package uart_arb_pkg;

    localparam int MAXBYTES_DEFAULT = 8;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef UART_ARB_CRLF_EN
    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        CR,
        LF
    } arb_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } arb_state_t;
`endif

endpackage

// File: rtl/uart_arb_rr.sv
// ---------------------------------------------------------------------------
// uart_arb_rr
// Two-way round-robin pick. A lone requester wins outright; on a tie the
// requester that was not granted last time wins.
// Ports:
//   req_valid  [1:0] in  : per-requester pending flags
//   last_grant       in  : index of the most recently granted requester
//   winner           out : index of the requester picked this cycle
//   any              out : at least one requester is pending
// ---------------------------------------------------------------------------
module uart_arb_rr
    import uart_arb_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       winner,
    output logic       any
);

    // On a tie, alternate away from the last grant; otherwise the only
    // pending requester wins (req_valid[1] is the winner index directly).
    always_comb begin
        any = |req_valid;
        if (&req_valid) begin
            winner = ~last_grant;
        end else begin
            winner = req_valid[1];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Arbitrates two message requesters onto a single UART transmitter. A
// granted message is latched and streamed byte by byte through a
// start/ready handshake with the transmitter.
// Configuration macro: UART_ARB_CRLF_EN -- when defined, every non-empty
// message is followed by CR (0x0D) and LF (0x0A).
// Ports:
//   clk                      in  : system clock, rising edge
//   rst                      in  : synchronous active-high reset
//   req_valid  [1:0]         in  : per-requester message pending
//   req_ready  [1:0]         out : one-cycle message-accepted pulse
//   req_buf0/1 [8*MAXBYTES]  in  : message bytes, byte 0 in [7:0], sent first
//   req_cnt0/1 [3:0]         in  : message byte count
//   tstart                   out : one-cycle start pulse to the transmitter
//   tbus       [7:0]         out : byte presented to the transmitter
//   tready                   in  : transmitter idle
//   busy                     out : FSM is not in IDLE
//   grant                    out : index of the most recently accepted requester
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int MAXBYTES = MAXBYTES_DEFAULT
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [8*MAXBYTES-1:0] req_buf0,
    input  logic [8*MAXBYTES-1:0] req_buf1,
    input  logic [3:0]            req_cnt0,
    input  logic [3:0]            req_cnt1,
    output logic                  tstart,
    output logic [7:0]            tbus,
    input  logic                  tready,
    output logic                  busy,
    output logic                  grant
);

    // The byte index must reach cnt+2 so the CR and LF slots can follow
    // the last message byte, and must be at least as wide as req_cnt so
    // clamping compares the full incoming count.
    localparam int CW = ($clog2(MAXBYTES + 3) > 4) ? $clog2(MAXBYTES + 3) : 4;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAXBYTES);

    arb_state_t            state;
    logic [8*MAXBYTES-1:0] msg_buf;
    logic [CW-1:0]         msg_cnt;
    logic [CW-1:0]         idx;
    logic [CW-1:0]         idx_next;
    logic [CW-1:0]         cnt_in;
    logic [CW-1:0]         cnt_clamped;
    logic [8*MAXBYTES-1:0] sel_buf;
    logic [7:0]            cur_byte;
    logic                  winner;
    logic                  any;

    uart_arb_rr u_rr (
        .req_valid  (req_valid),
        .last_grant (grant),
        .winner     (winner),
        .any        (any)
    );

    // Select the winner's message and clamp oversized counts so the byte
    // index never walks past the end of the buffer.
    always_comb begin
        sel_buf = winner ? req_buf1 : req_buf0;
        cnt_in  = winner ? CW'(req_cnt1) : CW'(req_cnt0);
        if (cnt_in > MAX_CNT) begin
            cnt_clamped = MAX_CNT;
        end else begin
            cnt_clamped = cnt_in;
        end
    end

    // Byte currently addressed by idx within the latched message.
    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < MAXBYTES; i++) begin
            if (idx == CW'(i)) begin
                cur_byte = msg_buf[8*i +: 8];
            end
        end
        idx_next = idx + CW'(1);
    end

    // Main FSM. All outputs are registered; busy is updated alongside
    // every state change so it always mirrors "state != IDLE".
    // Acceptance is blocked while req_ready is still high so a requester
    // gets one cycle to drop or replace its request after the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 2'b00;
            tstart    <= 1'b0;
            tbus      <= 8'h00;
            busy      <= 1'b0;
            grant     <= 1'b1;
            idx       <= '0;
            msg_buf   <= '0;
            msg_cnt   <= '0;
        end else begin
            req_ready <= 2'b00;
            tstart    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any && (req_ready == 2'b00)) begin
                        req_ready <= winner ? 2'b10 : 2'b01;
                        msg_buf   <= sel_buf;
                        msg_cnt   <= cnt_clamped;
                        grant     <= winner;
                        idx       <= '0;
                        if (cnt_clamped == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= SEND;
                            busy  <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (tready) begin
                        tstart <= 1'b1;
                        tbus   <= cur_byte;
                        state  <= WAIT;
                    end
                end

                // The transmitter drops tready once it has taken the byte;
                // only then is the slot considered consumed.
                WAIT: begin
                    if (!tready) begin
                        idx <= idx_next;
                        if (idx_next < msg_cnt) begin
                            state <= SEND;
`ifdef UART_ARB_CRLF_EN
                        end else if (idx_next == msg_cnt) begin
                            state <= CR;
                        end else if (idx_next == (msg_cnt + CW'(1))) begin
                            state <= LF;
`endif
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

`ifdef UART_ARB_CRLF_EN
                CR: begin
                    if (tready) begin
                        tstart <= 1'b1;
                        tbus   <= ASCII_CR;
                        state  <= WAIT;
                    end
                end

                LF: begin
                    if (tready) begin
                        tstart <= 1'b1;
                        tbus   <= ASCII_LF;
                        state  <= WAIT;
                    end
                end
`endif

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter. Messages are queued per
// requester; a reference model predicts the grant order and the byte
// stream, and a monitor compares every req_ready pulse and tstart against
// those predictions.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int MB = 8;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  cnt;
    } msg_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_buf0;
    logic [63:0] req_buf1;
    logic [3:0]  req_cnt0;
    logic [3:0]  req_cnt1;
    logic        tstart;
    logic [7:0]  tbus;
    logic        tready;
    logic        busy;
    logic        grant;
    logic        valid0;
    logic        valid1;

    assign req_valid = {valid1, valid0};

    msg_t        drv_q0[$];
    msg_t        drv_q1[$];
    msg_t        mdl_q0[$];
    msg_t        mdl_q1[$];
    logic [7:0]  exp_bytes[$];
    logic        exp_grant[$];

    int          tests = 0;
    int          fails = 0;
    int          tx_count = 0;
    int          busy_lo = 10;
    int          busy_hi = 10;
    bit          drv_en = 1'b0;
    bit          model_grant = 1'b1;

    uart_tx_arbiter #(.MAXBYTES(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_buf0  (req_buf0),
        .req_buf1  (req_buf1),
        .req_cnt0  (req_cnt0),
        .req_cnt1  (req_cnt1),
        .tstart    (tstart),
        .tbus      (tbus),
        .tready    (tready),
        .busy      (busy),
        .grant     (grant)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyReset();
        rst    = 1'b1;
        drv_en = 1'b0;
        repeat (2) @(negedge clk);
        drv_q0.delete();
        drv_q1.delete();
        mdl_q0.delete();
        mdl_q1.delete();
        exp_bytes.delete();
        exp_grant.delete();
        model_grant = 1'b1;
        rst = 1'b0;
    endtask

    task automatic addMsg(input int r, input logic [63:0] d, input logic [3:0] c);
        msg_t m;
        m.data = d;
        m.cnt  = c;
        if (r == 0) begin
            drv_q0.push_back(m);
            mdl_q0.push_back(m);
        end else begin
            drv_q1.push_back(m);
            mdl_q1.push_back(m);
        end
    endtask

    // Reference model: both requesters are presented together and each
    // re-requests immediately, so whenever both still have messages the
    // grant alternates; a requester with messages left alone is served
    // back to back. Each message yields min(cnt, MB) bytes, low byte first.
    task automatic applyStimulus();
        while (mdl_q0.size() > 0 || mdl_q1.size() > 0) begin
            bit   w;
            msg_t m;
            int   n;
            if (mdl_q0.size() > 0 && mdl_q1.size() > 0) begin
                w = ~model_grant;
            end else begin
                w = (mdl_q1.size() > 0);
            end
            m = w ? mdl_q1.pop_front() : mdl_q0.pop_front();
            model_grant = w;
            exp_grant.push_back(w);
            n = (int'(m.cnt) > MB) ? MB : int'(m.cnt);
            for (int k = 0; k < n; k++) begin
                exp_bytes.push_back(m.data[8*k +: 8]);
            end
`ifdef UART_ARB_CRLF_EN
            if (n > 0) begin
                exp_bytes.push_back(8'h0D);
                exp_bytes.push_back(8'h0A);
            end
`endif
        end
        @(negedge clk);
        drv_en = 1'b1;
    endtask

    task automatic waitDone(input string name);
        int cyc = 0;
        while ((drv_q0.size() > 0 || drv_q1.size() > 0 || valid0 || valid1 ||
                exp_bytes.size() > 0 || exp_grant.size() > 0 || busy) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, "_timeout"}, 64'(cyc >= 5000), 64'd0);
        checkOutput({name, "_busy_idle"}, 64'(busy), 64'd0);
        checkOutput({name, "_bytes_left"}, 64'(exp_bytes.size()), 64'd0);
        drv_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Requester drivers: hold a message until its req_ready pulse, then
    // load the next queued message (or drop valid) on the following negedge.
    initial begin
        msg_t m;
        valid0   = 1'b0;
        valid1   = 1'b0;
        req_buf0 = '0;
        req_buf1 = '0;
        req_cnt0 = '0;
        req_cnt1 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                valid0 = 1'b0;
                valid1 = 1'b0;
            end else begin
                if (valid0 && req_ready[0]) valid0 = 1'b0;
                if (valid1 && req_ready[1]) valid1 = 1'b0;
                if (!valid0 && drv_en && drv_q0.size() > 0) begin
                    m = drv_q0.pop_front();
                    req_buf0 = m.data;
                    req_cnt0 = m.cnt;
                    valid0   = 1'b1;
                end
                if (!valid1 && drv_en && drv_q1.size() > 0) begin
                    m = drv_q1.pop_front();
                    req_buf1 = m.data;
                    req_cnt1 = m.cnt;
                    valid1   = 1'b1;
                end
            end
        end
    end

    // UART transmitter model: goes busy the edge after a start pulse and
    // stays busy for a bounded random number of cycles.
    initial begin
        tready = 1'b1;
        forever begin
            @(negedge clk);
            if (tstart && !rst) begin
                @(posedge clk);
                #1 tready = 1'b0;
                repeat ($urandom_range(busy_hi, busy_lo)) @(posedge clk);
                #1 tready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every accept pulse and start pulse.
    initial begin
        logic       prev_ts;
        logic [7:0] last_tbus;
        logic       w;
        prev_ts   = 1'b0;
        last_tbus = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ts   = 1'b0;
                last_tbus = 8'h00;
            end else begin
                if (req_ready != 2'b00) begin
                    if (exp_grant.size() == 0) begin
                        checkOutput("unexpected_req_ready", 64'(req_ready), 64'd0);
                    end else begin
                        w = exp_grant.pop_front();
                        checkOutput("req_ready", 64'(req_ready), w ? 64'd2 : 64'd1);
                        checkOutput("grant", 64'(grant), 64'(w));
                    end
                end
                if (tstart) begin
                    checkOutput("tstart_while_uart_busy", 64'(tready), 64'd1);
                    checkOutput("tstart_back_to_back", 64'(prev_ts), 64'd0);
                    checkOutput("busy_during_tx", 64'(busy), 64'd1);
                    if (exp_bytes.size() == 0) begin
                        checkOutput("unexpected_tstart", 64'(tstart), 64'd0);
                    end else begin
                        checkOutput("tbus", 64'(tbus), 64'(exp_bytes.pop_front()));
                    end
                    last_tbus = tbus;
                    tx_count++;
                end else begin
                    checkOutput("tbus_hold", 64'(tbus), 64'(last_tbus));
                end
                prev_ts = tstart;
            end
        end
    end

    initial begin
        int base;
        int cyc;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_tstart", 64'(tstart), 64'd0);
        checkOutput("reset_tbus", 64'(tbus), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_grant", 64'(grant), 64'd1);
        rst = 1'b0;

        $display("[TB] single message");
        busy_lo = 10; busy_hi = 10;
        addMsg(0, 64'h434241, 4'd3);
        applyStimulus();
        waitDone("single");

        $display("[TB] simultaneous requests");
        applyReset();
        busy_lo = 2; busy_hi = 4;
        addMsg(0, 64'h11, 4'd1);
        addMsg(1, 64'h22, 4'd1);
        applyStimulus();
        waitDone("simultaneous");

        $display("[TB] repeated contention");
        for (int i = 0; i < 2; i++) begin
            addMsg(0, {$urandom, $urandom}, 4'($urandom_range(1, 3)));
            addMsg(1, {$urandom, $urandom}, 4'($urandom_range(1, 3)));
        end
        applyStimulus();
        waitDone("contention");

        $display("[TB] count edge cases");
        addMsg(0, 64'hDEAD, 4'd0);
        applyStimulus();
        waitDone("cnt_zero");
        addMsg(0, {$urandom, $urandom}, 4'd15);
        applyStimulus();
        waitDone("cnt_clamp");

        $display("[TB] crlf message");
        addMsg(0, 64'h5A, 4'd1);
        applyStimulus();
        waitDone("crlf");

        $display("[TB] random traffic");
        busy_lo = 1; busy_hi = 6;
        for (int r = 0; r < 6; r++) begin
            int n0;
            int n1;
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            for (int i = 0; i < n0; i++) addMsg(0, {$urandom, $urandom}, 4'($urandom_range(0, 15)));
            for (int i = 0; i < n1; i++) addMsg(1, {$urandom, $urandom}, 4'($urandom_range(0, 15)));
            applyStimulus();
            waitDone("random");
        end

        $display("[TB] reset mid-message");
        applyReset();
        busy_lo = 3; busy_hi = 3;
        base = tx_count;
        addMsg(0, 64'h44434241, 4'd4);
        applyStimulus();
        cyc = 0;
        while (tx_count < base + 2 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("midreset_wait_timeout", 64'(cyc >= 1000), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("midreset_tstart", 64'(tstart), 64'd0);
        checkOutput("midreset_tbus", 64'(tbus), 64'd0);
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_grant", 64'(grant), 64'd1);
        @(negedge clk);
        drv_en = 1'b0;
        exp_bytes.delete();
        exp_grant.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        checkOutput("midreset_no_more_tstart", 64'(tx_count - base), 64'd2);
        checkOutput("midreset_busy_after", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL take parameter MAXBYTES, default 8, meaning the maximum bytes per message.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic SHALL run on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 2, the per-requester message-pending flag.
REQ-005 The block SHALL have port req_ready, output, 2, the per-requester one-cycle message-accepted pulse.
REQ-006 The block SHALL have ports req_buf0 and req_buf1, input, 8*MAXBYTES, the message bytes; byte k sits in [8k+7:8k] and byte 0 is sent first.
REQ-007 The block SHALL have ports req_cnt0 and req_cnt1, input, 4, the message byte count.
REQ-008 The block SHALL have port tstart, output, 1, the one-cycle start pulse to the UART transmitter.
REQ-009 The block SHALL have port tbus, output, 8, the byte presented to the UART transmitter.
REQ-010 The block SHALL have port tready, input, 1, the UART transmitter idle flag.
REQ-011 The block SHALL have port busy, output, 1, asserted high whenever the FSM is not in IDLE.
REQ-012 The block SHALL have port grant, output, 1, the index of the most recently accepted requester.

Function
REQ-013 The FSM SHALL have states IDLE, SEND, WAIT and, only when the macro is defined, CR and LF.
REQ-014 In IDLE with any req_valid high, the block SHALL pick a requester by round-robin:
- a single requester wins outright;
- if both are valid, the one not equal to grant wins.
REQ-015 In the same cycle, the block SHALL:
- pulse req_ready[winner] for exactly one cycle;
- latch that requester's buf and cnt;
- update grant;
- move to SEND.
REQ-016 A requester SHALL hold req_valid, buf and cnt stable until its req_ready pulse; data is sampled only in the pulse cycle.
REQ-017 A latched cnt greater than MAXBYTES SHALL be clamped to MAXBYTES.
REQ-018 A latched cnt of 0 SHALL return the FSM to IDLE with no tstart and no CR/LF.
REQ-019 In SEND, when tready is 1, the block SHALL:
- pulse tstart for one cycle with tbus = byte[idx];
- move to WAIT.
REQ-020 tbus SHALL hold its value from tstart until the next tstart.
REQ-021 In WAIT, once tready has been sampled 0, the block SHALL increment idx; it SHALL then go to SEND if idx < cnt, otherwise to IDLE (or to CR when the macro is defined).
REQ-022 The block SHALL never assert tstart while tready is 0, and SHALL never assert it on two consecutive cycles.
REQ-023 The block SHALL assert the first tstart no earlier than 1 cycle after req_ready.
REQ-024 With tready held at 1, the block SHALL accept a new message no earlier than 1 cycle after returning to IDLE.
REQ-025 A req_valid that deasserts before it is granted SHALL be ignored, with no req_ready.

Reset
REQ-026 When rst is 1 at a clock edge, the block SHALL:
- enter IDLE;
- set req_ready=0, tstart=0, tbus=0x00, busy=0, grant=1 (so requester 0 wins first on a tie) and idx=0.
REQ-027 A reset mid-message SHALL abort the message; no further tstart is issued and the requester is not re-acknowledged.

Configuration
REQ-028 With UART_ARB_CRLF_EN defined, every message of nonzero cnt SHALL be followed by 0x0D and then 0x0A, sent through CR and LF using the same SEND/WAIT handshake; busy stays 1 until LF completes.
REQ-029 Without UART_ARB_CRLF_EN, the CR and LF states and their logic SHALL be absent, and only message bytes are sent.

Structure
REQ-030 Package uart_arb_pkg SHALL hold:
- the FSM state typedef;
- constants ASCII_CR (0x0D) and ASCII_LF (0x0A);
- the MAXBYTES default.
REQ-031 The two-requester round-robin pick SHALL be a sub-module named uart_arb_rr, with inputs req_valid and last grant and outputs winner and any.
REQ-032 The RTL SHALL connect directly to the existing uart_tx ports start, tbus and ready.

Verification
REQ-033 The bench SHALL cover these scenarios:
- Single message: req_valid=01, cnt0=3, buf0=0x434241, tready model busy 10 cycles per byte -> tstart ×3 with tbus 0x41, 0x42, 0x43; one req_ready[0] pulse; busy falls after the third byte.
- Simultaneous requests: req_valid=11 after reset, cnt=1 each -> requester 0 is served first, then requester 1; grant goes 0 then 1.
- Repeated contention: both valid for 4 messages -> grant sequence alternates 0,1,0,1.
- Count edge cases: cnt0=0 -> req_ready[0] pulses with no tstart; cnt0=15 with MAXBYTES=8 -> exactly 8 tstarts.
- Reset mid-message: rst asserted after the 2nd of 4 bytes -> no further tstart; all outputs at reset values on the next cycle.
- CRLF build: UART_ARB_CRLF_EN defined, cnt0=1, buf0=0x5A -> tbus sequence 0x5A, 0x0D, 0x0A.
